// File: rtl/oam_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_pkg
// Description : Shared types and constants for the OAM DMA controller.
//               Holds the controller state encoding, transfer length,
//               trigger register address, and the echo-page fold helper.
//               The helper is only used when OAM_DMA_ECHO_FOLD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package oam_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        ARM_R = 2'd3
    } dma_state_t;

    localparam int          DMA_LEN_C    = 160;
    localparam logic [15:0] DMA_REG_C    = 16'hFF46;
    localparam logic [2:0]  VRAM_PAGE_HI = 3'b100;
    localparam logic [1:0]  PH_LAST      = 2'd3;
    localparam logic [7:0]  ECHO_BASE    = 8'hE0;

    // Pages E0-FF mirror C0-DF; clearing bit 5 maps the echo page onto WRAM.
    function automatic logic [7:0] echo_fold(input logic [7:0] page);
        return (page >= ECHO_BASE) ? (page & 8'hDF) : page;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_phase.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_phase
// Description : Free-running 2-bit dot phase within the machine cycle.
//               Decodes the machine-cycle boundary and the write-strobe lead.
// Ports       : clk_i          dot clock
//               nreset_i       asynchronous active-low reset
//               wrap_o         ph==3; the coming edge is the M-cycle boundary
//               strobe_next_o  ph==2; the coming edge enters the strobe phase
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_phase
    import oam_dma_pkg::*;
(
    input  logic clk_i,
    input  logic nreset_i,
    output logic wrap_o,
    output logic strobe_next_o
);

    logic [1:0] ph_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            ph_q <= 2'd0;
        end else begin
            ph_q <= ph_q + 2'd1;
        end
    end

    assign wrap_o        = (ph_q == PH_LAST);
    assign strobe_next_o = (ph_q == (PH_LAST - 2'd1));

endmodule
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_ctrl
// Description : OAM DMA sequencer. A CPU write to DMA_REG copies DMA_LEN
//               bytes from page {d,00} into OAM, one byte per machine cycle,
//               and claims the OAM address bus while the copy runs.
// Ports       : clk, nreset        dot clock, async active-low reset
//               cpu_wr, a, d       CPU write strobe, address, data
//               reg_q              trigger register readback
//               dma_run            transfer active (bus owned)
//               dma_a              source address {src_act, idx}
//               oam_addr_ndma      active-low DMA address enable
//               vram_to_oam        source page lies in 80-9F
//               oam_nwr            active-low OAM write strobe
//               dma_done           one-clk pulse after the final byte
// Config      : OAM_DMA_ECHO_FOLD_EN - fold source pages E0-FF onto C0-DF
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl
    import oam_dma_pkg::*;
#(
    parameter int          DMA_LEN = DMA_LEN_C,
    parameter logic [15:0] DMA_REG = DMA_REG_C
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cpu_wr,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    output logic [7:0]  reg_q,
    output logic        dma_run,
    output logic [15:0] dma_a,
    output logic        oam_addr_ndma,
    output logic        vram_to_oam,
    output logic        oam_nwr,
    output logic        dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    logic       wrap;
    logic       strobe_next;

    dma_state_t state_q, state_d;
    logic [7:0] src_pend_q, src_pend_d;
    logic [7:0] src_act_q, src_act_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] reg_d;
    logic       start_req_q, start_req_d;
    logic       cnt_q, cnt_d;          // one boundary already seen since (re)arm
    logic       run_d, nwr_d, vram_d, done_d;

    logic       w_wr;
    logic       w_last;
    logic [7:0] w_idx_step;
    logic [7:0] w_src_load;

    oam_dma_phase u_phase (
        .clk_i         (clk),
        .nreset_i      (nreset),
        .wrap_o        (wrap),
        .strobe_next_o (strobe_next)
    );

    assign w_wr       = cpu_wr && (a == DMA_REG);
    assign w_last     = (idx_q == LAST_IDX);
    assign w_idx_step = w_last ? 8'd0 : (idx_q + 8'd1);

`ifdef OAM_DMA_ECHO_FOLD_EN
    assign w_src_load = echo_fold(src_pend_q);
`else
    assign w_src_load = src_pend_q;
`endif

    // The arming delay counts M-cycle boundaries starting with the edge that
    // arms (or re-arms); the second one counted loads the new transfer. That
    // gives 5-8 clk from an idle write, and exactly one M-cycle of gap when a
    // write lands on the final byte's boundary.
    always_comb begin
        state_d     = state_q;
        src_pend_d  = src_pend_q;
        src_act_d   = src_act_q;
        idx_d       = idx_q;
        reg_d       = reg_q;
        start_req_d = start_req_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;

        if (w_wr) begin
            src_pend_d = d;
            reg_d      = d;
        end

        case (state_q)
            IDLE: begin
                if (start_req_q) begin
                    state_d     = ARM;
                    start_req_d = 1'b0;
                    cnt_d       = wrap;
                end else if (w_wr) begin
                    start_req_d = 1'b1;
                end
            end
            ARM: begin
                if (w_wr) begin
                    cnt_d = wrap;
                end else if (wrap) begin
                    if (cnt_q) begin
                        src_act_d = w_src_load;
                        idx_d     = 8'd0;
                        state_d   = RUN;
                    end else begin
                        cnt_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (wrap) begin
                    idx_d = w_idx_step;
                end
                if (wrap && w_last) begin
                    done_d  = 1'b1;
                    state_d = w_wr ? ARM : IDLE;
                end else if (w_wr) begin
                    state_d = ARM_R;
                end
                if (w_wr) begin
                    cnt_d = wrap;
                end
            end
            ARM_R: begin
                // Old transfer keeps stepping (no done pulse) until reload.
                if (wrap) begin
                    idx_d = w_idx_step;
                end
                if (w_wr) begin
                    cnt_d = wrap;
                end else if (wrap) begin
                    if (cnt_q) begin
                        src_act_d = w_src_load;
                        idx_d     = 8'd0;
                        state_d   = RUN;
                    end else begin
                        cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        run_d  = (state_d == RUN) || (state_d == ARM_R);
        // Strobe is registered one edge early so it is low for all of ph 3.
        nwr_d  = !(run_d && strobe_next);
        vram_d = run_d && (src_act_d[7:5] == VRAM_PAGE_HI);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            src_pend_q  <= 8'hFF;
            src_act_q   <= 8'hFF;
            idx_q       <= 8'd0;
            reg_q       <= 8'hFF;
            start_req_q <= 1'b0;
            cnt_q       <= 1'b0;
            dma_run     <= 1'b0;
            oam_nwr     <= 1'b1;
            vram_to_oam <= 1'b0;
            dma_done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_pend_q  <= src_pend_d;
            src_act_q   <= src_act_d;
            idx_q       <= idx_d;
            reg_q       <= reg_d;
            start_req_q <= start_req_d;
            cnt_q       <= cnt_d;
            dma_run     <= run_d;
            oam_nwr     <= nwr_d;
            vram_to_oam <= vram_d;
            dma_done    <= done_d;
        end
    end

    assign dma_a         = {src_act_q, idx_q};
    assign oam_addr_ndma = ~dma_run;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma_ctrl
// Description : Self-checking bench for oam_dma_ctrl. Expected OAM source
//               addresses are queued when a transfer is requested and popped
//               on every observed write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [7:0]  d = 8'h00;
    logic [7:0]  reg_q;
    logic        dma_run;
    logic [15:0] dma_a;
    logic        oam_addr_ndma;
    logic        vram_to_oam;
    logic        oam_nwr;
    logic        dma_done;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;

    logic [1:0]  tb_ph;
    logic [15:0] exp_addr[$];
    logic [15:0] e_addr;

    oam_dma_ctrl dut (
        .clk           (clk),
        .nreset        (nreset),
        .cpu_wr        (cpu_wr),
        .a             (a),
        .d             (d),
        .reg_q         (reg_q),
        .dma_run       (dma_run),
        .dma_a         (dma_a),
        .oam_addr_ndma (oam_addr_ndma),
        .vram_to_oam   (vram_to_oam),
        .oam_nwr       (oam_nwr),
        .dma_done      (dma_done)
    );

    always #5 clk = ~clk;

    // Reference phase: ph is 0 after reset and advances every clk.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) tb_ph <= 2'd0;
        else         tb_ph <= tb_ph + 2'd1;
    end

    // Scoreboard: every strobe must match the next queued source address
    // and fall in phase 3.
    always @(negedge clk) begin
        if (nreset) begin
            if (dma_done === 1'b1) done_cnt++;
            if (oam_nwr === 1'b0) begin
                strobe_cnt++;
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: dma_a=%h with no byte expected", dma_a);
                end else begin
                    e_addr = exp_addr.pop_front();
                    if (dma_a !== e_addr || tb_ph !== 2'd3) begin
                        errors++;
                        $display("FAIL strobe_addr: got dma_a=%h ph=%0d, expected %h ph=3", dma_a, tb_ph, e_addr);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic push_run(input logic [7:0] page);
        for (int i = 0; i < 160; i++) exp_addr.push_back({page, 8'(i)});
    endtask

    // Returns #1 after the write edge; the write edge has ph == p.
    task automatic do_write(input logic [7:0] data, input logic [15:0] addr, input int p);
        while (tb_ph != 2'(p)) begin
            @(posedge clk); #1;
        end
        cpu_wr = 1'b1; a = addr; d = data;
        @(posedge clk); #1;
        cpu_wr = 1'b0; a = 16'h0000;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (dma_run !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic watch_run(input int n0, input int exp_len, input logic ev);
        int n = n0;
        int bad_v = 0;
        int bad_a = 0;
        while (dma_run === 1'b1 && n < 1000) begin
            if (vram_to_oam !== ev) bad_v++;
            if (dma_a[7:0] > 8'h9F || oam_addr_ndma !== 1'b0) bad_a++;
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n != exp_len) begin errors++; $display("FAIL run_length: got %0d clk, expected %0d", n, exp_len); end
        checks++;
        if (dma_done !== 1'b1) begin errors++; $display("FAIL done_at_fall: got %b, expected 1", dma_done); end
        checks++;
        if (bad_v != 0) begin errors++; $display("FAIL vram_to_oam: %0d cycles differ from expected %b", bad_v, ev); end
        checks++;
        if (bad_a != 0) begin errors++; $display("FAIL run_bus: %0d cycles with low byte >9F or ndma high, expected 0", bad_a); end
        @(posedge clk); #1;
        checks++;
        if (dma_done !== 1'b0 || oam_addr_ndma !== 1'b1) begin
            errors++; $display("FAIL after_run: got done=%b ndma=%b, expected 0 1", dma_done, oam_addr_ndma);
        end
    endtask

    task automatic run_one(input logic [7:0] data, input int p, input int exp_lat,
                           input logic ev, input logic [7:0] exp_page);
        int lat;
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        push_run(exp_page);
        do_write(data, 16'hFF46, p);
        wait_start(lat);
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL start_latency_%h: got %0d clk, expected %0d", data, lat, exp_lat); end
        checks++;
        if (dma_a !== {exp_page, 8'h00}) begin errors++; $display("FAIL first_addr: got %h, expected %h", dma_a, {exp_page, 8'h00}); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (oam_nwr !== 1'b1) begin errors++; $display("FAIL nwr_early_%0d: got %b, expected 1", k, oam_nwr); end
            @(posedge clk); #1;
        end
        checks++;
        if (oam_nwr !== 1'b0) begin errors++; $display("FAIL nwr_first_fall: got %b, expected 0", oam_nwr); end
        watch_run(3, 640, ev);
        checks++;
        if (done_cnt - d0 != 1 || strobe_cnt - s0 != 160 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL run_totals: got done=%0d strobes=%0d left=%0d, expected 1 160 0",
                     done_cnt - d0, strobe_cnt - s0, exp_addr.size());
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #12;
        checks++;
        if ({reg_q, dma_run, oam_addr_ndma, oam_nwr, dma_done, vram_to_oam} !== {8'hFF, 5'b01100}) begin
            errors++;
            $display("FAIL reset_flags: got reg=%h run=%b ndma=%b nwr=%b done=%b vram=%b, expected FF 0 1 1 0 0",
                     reg_q, dma_run, oam_addr_ndma, oam_nwr, dma_done, vram_to_oam);
        end
        checks++;
        if (dma_a !== 16'hFF00) begin errors++; $display("FAIL reset_dma_a: got %h, expected FF00", dma_a); end
        @(posedge clk); #1;
        nreset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (dma_run !== 1'b0 || oam_nwr !== 1'b1) begin
            errors++; $display("FAIL idle_after_reset: got run=%b nwr=%b, expected 0 1", dma_run, oam_nwr);
        end
    endtask

    task automatic test_bad_addr();
        int seen = 0;
        do_write(8'h55, 16'hFF45, 0);
        repeat (12) begin
            if (dma_run !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0 || reg_q !== 8'hFF) begin
            errors++; $display("FAIL other_addr: got run_cycles=%0d reg=%h, expected 0 FF", seen, reg_q);
        end
    endtask

    task automatic test_basic();
        run_one(8'hC1, 0, 7, 1'b0, 8'hC1);
        checks++;
        if (reg_q !== 8'hC1) begin errors++; $display("FAIL readback_C1: got %h, expected C1", reg_q); end
    endtask

    task automatic test_vram();
        run_one(8'h85, 2, 5, 1'b1, 8'h85);
        run_one(8'h7F, 3, 8, 1'b0, 8'h7F);
    endtask

    task automatic test_fold();
`ifdef OAM_DMA_ECHO_FOLD_EN
        run_one(8'hFE, 1, 6, 1'b0, 8'hDE);
`else
        run_one(8'hFE, 1, 6, 1'b0, 8'hFE);
`endif
        checks++;
        if (reg_q !== 8'hFE) begin errors++; $display("FAIL readback_FE: got %h, expected FE", reg_q); end
    endtask

    task automatic test_restart();
        int lat;
        int n = 0;
        int d0 = done_cnt;
        push_run(8'hC0);
        do_write(8'hC0, 16'hFF46, 0);
        wait_start(lat);
        checks++;
        if (lat != 7) begin errors++; $display("FAIL restart_latency: got %0d, expected 7", lat); end
        while (dma_a !== 16'hC032 && n < 800) begin @(posedge clk); #1; n++; end
        // Bytes 50 and 51 of the old transfer still go out during the re-arm.
        while (exp_addr.size() > 2) void'(exp_addr.pop_back());
        push_run(8'hD0);
        do_write(8'hD0, 16'hFF46, 0);
        checks++;
        if (dma_a !== 16'hC032 || dma_run !== 1'b1) begin
            errors++; $display("FAIL restart_hold: got dma_a=%h run=%b, expected C032 1", dma_a, dma_run);
        end
        watch_run(201, 848, 1'b0);
        checks++;
        if (done_cnt - d0 != 1 || exp_addr.size() != 0 || reg_q !== 8'hD0) begin
            errors++;
            $display("FAIL restart_totals: got done=%0d left=%0d reg=%h, expected 1 0 D0",
                     done_cnt - d0, exp_addr.size(), reg_q);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n = 0;
        int seen = 0;
        int s0;
        push_run(8'h12);
        do_write(8'h12, 16'hFF46, 1);
        wait_start(lat);
        while (dma_a !== 16'h1250 && n < 800) begin @(posedge clk); #1; n++; end
        while (tb_ph != 2'd3 && n < 810) begin @(posedge clk); #1; n++; end
        checks++;
        if (oam_nwr !== 1'b0) begin errors++; $display("FAIL mid_strobe: got nwr=%b, expected 0", oam_nwr); end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (dma_run !== 1'b0 || oam_nwr !== 1'b1 || dma_a !== 16'hFF00 || oam_addr_ndma !== 1'b1 || reg_q !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset: got run=%b nwr=%b dma_a=%h ndma=%b reg=%h, expected 0 1 FF00 1 FF",
                     dma_run, oam_nwr, dma_a, oam_addr_ndma, reg_q);
        end
        exp_addr.delete();
        @(posedge clk); #1;
        nreset = 1'b1;
        s0 = strobe_cnt;
        repeat (20) begin
            if (dma_run !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0 || strobe_cnt != s0) begin
            errors++; $display("FAIL quiet_after_reset: got run_cycles=%0d strobes=%0d, expected 0 0", seen, strobe_cnt - s0);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int n = 0;
        int d0 = done_cnt;
        push_run(8'h30);
        do_write(8'h30, 16'hFF46, 0);
        wait_start(lat);
        while (dma_a !== 16'h309F && n < 800) begin @(posedge clk); #1; n++; end
        while (tb_ph != 2'd3 && n < 810) begin @(posedge clk); #1; n++; end
        push_run(8'h31);
        cpu_wr = 1'b1; a = 16'hFF46; d = 8'h31;
        @(posedge clk); #1;
        cpu_wr = 1'b0; a = 16'h0000;
        checks++;
        if (dma_done !== 1'b1 || dma_run !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got done=%b run=%b, expected 1 0", dma_done, dma_run);
        end
        wait_start(lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL b2b_gap: got %0d clk low, expected 4", lat); end
        checks++;
        if (dma_a !== 16'h3100) begin errors++; $display("FAIL b2b_addr: got %h, expected 3100", dma_a); end
        watch_run(0, 640, 1'b0);
        checks++;
        if (done_cnt - d0 != 2 || exp_addr.size() != 0) begin
            errors++; $display("FAIL b2b_totals: got done=%0d left=%0d, expected 2 0", done_cnt - d0, exp_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_bad_addr();
        test_basic();
        test_vram();
        test_fold();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
